// File: rtl/ysyx_22040750_memrd_arbiter.sv
// Read-channel arbiter: shares one AXI AR/R port between icache and dcache.
// One burst in flight at a time; the R beats are steered to the granted cache.
module ysyx_22040750_memrd_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_ic_araddr,
  input  logic [7:0]  I_ic_arlen,
  input  logic        I_ic_arvalid,
  output logic        O_ic_arready,
  output logic [63:0] O_ic_rdata,
  output logic        O_ic_rvalid,
  output logic        O_ic_rlast,
  input  logic [31:0] I_dc_araddr,
  input  logic [7:0]  I_dc_arlen,
  input  logic        I_dc_arvalid,
  output logic        O_dc_arready,
  output logic [63:0] O_dc_rdata,
  output logic        O_dc_rvalid,
  output logic        O_dc_rlast,
  output logic [31:0] O_mem_araddr,
  output logic [7:0]  O_mem_arlen,
  output logic [2:0]  O_mem_arsize,
  output logic        O_mem_arvalid,
  input  logic        I_mem_arready,
  input  logic [63:0] I_mem_rdata,
  input  logic        I_mem_rvalid,
  input  logic        I_mem_rlast,
  output logic        O_mem_rready,
  output logic [1:0]  O_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; arready is only offered in IDLE, rready is always high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t      state;
  logic        grant_dc;
  logic        last_dc;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic        any_req;
  logic        pick_dc;
  logic        accept;
  logic        in_r;

  assign any_req = I_ic_arvalid | I_dc_arvalid;

  // On a tie, round-robin favours whoever did not finish the previous burst.
  always_comb begin
    pick_dc = I_dc_arvalid;
    if (I_ic_arvalid && I_dc_arvalid) begin
      pick_dc = (RR_EN != 0) ? ~last_dc : 1'b1;
    end
  end

  assign accept = (state == S_IDLE) && any_req && !I_rst;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state    <= S_IDLE;
      grant_dc <= 1'b0;
      last_dc  <= 1'b0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_dc <= pick_dc;
            addr_q   <= pick_dc ? I_dc_araddr : I_ic_araddr;
            len_q    <= pick_dc ? I_dc_arlen : I_ic_arlen;
            state    <= S_AR;
          end
        end
        S_AR: begin
          if (I_mem_arready) state <= S_R;
        end
        S_R: begin
          if (I_mem_rvalid && I_mem_rlast) begin
            last_dc <= grant_dc;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_r = (state == S_R) && !I_rst;

  assign O_ic_arready  = accept & ~pick_dc;
  assign O_dc_arready  = accept & pick_dc;

  assign O_mem_araddr  = addr_q;
  assign O_mem_arlen   = len_q;
  assign O_mem_arsize  = 3'b011;
  assign O_mem_arvalid = (state == S_AR) && !I_rst;
  assign O_mem_rready  = 1'b1;

  assign O_ic_rdata    = I_mem_rdata;
  assign O_dc_rdata    = I_mem_rdata;
  assign O_ic_rvalid   = in_r & ~grant_dc & I_mem_rvalid;
  assign O_dc_rvalid   = in_r & grant_dc & I_mem_rvalid;
  assign O_ic_rlast    = in_r & ~grant_dc & I_mem_rvalid & I_mem_rlast;
  assign O_dc_rlast    = in_r & grant_dc & I_mem_rvalid & I_mem_rlast;

  assign O_dbg_state   = state;

endmodule

// File: tb/tb_ysyx_22040750_memrd_arbiter.sv
// Bench for the read arbiter: a round-robin and a fixed-priority instance run
// in lockstep on shared inputs; burst rows come from a table, beats via exp_q.
module tb_ysyx_22040750_memrd_arbiter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;

  typedef struct {
    bit          ic_v;
    logic [31:0] ic_a;
    logic [7:0]  ic_l;
    bit          dc_v;
    logic [31:0] dc_a;
    logic [7:0]  dc_l;
    int          ar_dly;
    bit          junk;
    bit          exp_dc_rr;
    bit          exp_dc_fp;
  } vec_t;

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic [31:0] I_ic_araddr, I_dc_araddr;
  logic [7:0]  I_ic_arlen, I_dc_arlen;
  logic        I_ic_arvalid, I_dc_arvalid;
  logic        I_mem_arready, I_mem_rvalid, I_mem_rlast;
  logic [63:0] I_mem_rdata;

  logic        ic_arready_rr, dc_arready_rr, ic_rvalid_rr, dc_rvalid_rr, ic_rlast_rr, dc_rlast_rr;
  logic [63:0] ic_rdata_rr, dc_rdata_rr;
  logic [31:0] araddr_rr;
  logic [7:0]  arlen_rr;
  logic [2:0]  arsize_rr;
  logic        arvalid_rr, rready_rr;
  logic [1:0]  state_rr;

  logic        ic_arready_fp, dc_arready_fp, ic_rvalid_fp, dc_rvalid_fp, ic_rlast_fp, dc_rlast_fp;
  logic [63:0] ic_rdata_fp, dc_rdata_fp;
  logic [31:0] araddr_fp;
  logic [7:0]  arlen_fp;
  logic [2:0]  arsize_fp;
  logic        arvalid_fp, rready_fp;
  logic [1:0]  state_fp;

  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  vec_t        tbl[8];

  ysyx_22040750_memrd_arbiter #(.RR_EN(1)) dut_rr (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_ic_araddr(I_ic_araddr), .I_ic_arlen(I_ic_arlen), .I_ic_arvalid(I_ic_arvalid),
    .O_ic_arready(ic_arready_rr), .O_ic_rdata(ic_rdata_rr), .O_ic_rvalid(ic_rvalid_rr),
    .O_ic_rlast(ic_rlast_rr),
    .I_dc_araddr(I_dc_araddr), .I_dc_arlen(I_dc_arlen), .I_dc_arvalid(I_dc_arvalid),
    .O_dc_arready(dc_arready_rr), .O_dc_rdata(dc_rdata_rr), .O_dc_rvalid(dc_rvalid_rr),
    .O_dc_rlast(dc_rlast_rr),
    .O_mem_araddr(araddr_rr), .O_mem_arlen(arlen_rr), .O_mem_arsize(arsize_rr),
    .O_mem_arvalid(arvalid_rr), .I_mem_arready(I_mem_arready), .I_mem_rdata(I_mem_rdata),
    .I_mem_rvalid(I_mem_rvalid), .I_mem_rlast(I_mem_rlast), .O_mem_rready(rready_rr),
    .O_dbg_state(state_rr)
  );

  ysyx_22040750_memrd_arbiter #(.RR_EN(0)) dut_fp (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_ic_araddr(I_ic_araddr), .I_ic_arlen(I_ic_arlen), .I_ic_arvalid(I_ic_arvalid),
    .O_ic_arready(ic_arready_fp), .O_ic_rdata(ic_rdata_fp), .O_ic_rvalid(ic_rvalid_fp),
    .O_ic_rlast(ic_rlast_fp),
    .I_dc_araddr(I_dc_araddr), .I_dc_arlen(I_dc_arlen), .I_dc_arvalid(I_dc_arvalid),
    .O_dc_arready(dc_arready_fp), .O_dc_rdata(dc_rdata_fp), .O_dc_rvalid(dc_rvalid_fp),
    .O_dc_rlast(dc_rlast_fp),
    .O_mem_araddr(araddr_fp), .O_mem_arlen(arlen_fp), .O_mem_arsize(arsize_fp),
    .O_mem_arvalid(arvalid_fp), .I_mem_arready(I_mem_arready), .I_mem_rdata(I_mem_rdata),
    .I_mem_rvalid(I_mem_rvalid), .I_mem_rlast(I_mem_rlast), .O_mem_rready(rready_fp),
    .O_dbg_state(state_fp)
  );

  // Clock and watchdog
  always #5 I_clk = ~I_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_miss=%0d", n_miss);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    I_ic_araddr = 32'd0; I_ic_arlen = 8'd0; I_ic_arvalid = 1'b0;
    I_dc_araddr = 32'd0; I_dc_arlen = 8'd0; I_dc_arvalid = 1'b0;
    I_mem_arready = 1'b0; I_mem_rvalid = 1'b0; I_mem_rlast = 1'b0;
    I_mem_rdata = 64'd0;
  endtask

  // Reset with requests and beats pending: everything handshake-related stays low.
  task automatic do_reset();
    @(negedge I_clk);
    I_rst = 1'b1;
    I_ic_arvalid = 1'b1; I_dc_arvalid = 1'b1;
    I_mem_rvalid = 1'b1; I_mem_rlast = 1'b1;
    I_mem_rdata = 64'h0123_4567_89ab_cdef;
    #1;
    chk("rst_arready_rr", {ic_arready_rr, dc_arready_rr}, 0);
    chk("rst_arready_fp", {ic_arready_fp, dc_arready_fp}, 0);
    chk("rst_rvalid_rr", {ic_rvalid_rr, dc_rvalid_rr, ic_rlast_rr, dc_rlast_rr}, 0);
    chk("rst_arvalid_rr", arvalid_rr, 0);
    @(negedge I_clk);
    #1;
    chk("rst_state_rr", state_rr, ST_IDLE);
    chk("rst_araddr_rr", araddr_rr, 0);
    chk("rst_arlen_rr", arlen_rr, 0);
    chk("rst_arsize_rr", arsize_rr, 3'b011);
    chk("rst_rready_rr", rready_rr, 1);
    chk("rst_rdata_ic", ic_rdata_rr, 64'h0123_4567_89ab_cdef);
    chk("rst_rdata_dc", dc_rdata_rr, 64'h0123_4567_89ab_cdef);
    @(negedge I_clk);
    I_rst = 1'b0;
    clear_inputs();
  endtask

  // Accept cycle, AR phase, then every beat; request lines held for the whole burst.
  task automatic serve(input vec_t v, input string tag);
    logic [31:0] a_rr, a_fp;
    logic [7:0]  l_rr, l_fp;
    logic [63:0] exp_d;
    a_rr = v.exp_dc_rr ? v.dc_a : v.ic_a;
    l_rr = v.exp_dc_rr ? v.dc_l : v.ic_l;
    a_fp = v.exp_dc_fp ? v.dc_a : v.ic_a;
    l_fp = v.exp_dc_fp ? v.dc_l : v.ic_l;
    @(negedge I_clk);
    I_ic_arvalid = v.ic_v; I_ic_araddr = v.ic_a; I_ic_arlen = v.ic_l;
    I_dc_arvalid = v.dc_v; I_dc_araddr = v.dc_a; I_dc_arlen = v.dc_l;
    I_mem_arready = 1'b0; I_mem_rvalid = 1'b0; I_mem_rlast = 1'b0;
    #1;
    chk({tag, "_idle_rr"}, state_rr, ST_IDLE);
    chk({tag, "_ic_arready_rr"}, ic_arready_rr, !v.exp_dc_rr);
    chk({tag, "_dc_arready_rr"}, dc_arready_rr, v.exp_dc_rr);
    chk({tag, "_ic_arready_fp"}, ic_arready_fp, !v.exp_dc_fp);
    chk({tag, "_dc_arready_fp"}, dc_arready_fp, v.exp_dc_fp);
    chk({tag, "_arvalid_idle"}, arvalid_rr, 0);
    for (int d = 0; d <= v.ar_dly; d++) begin
      @(negedge I_clk);
      I_mem_arready = (d == v.ar_dly);
      I_mem_rvalid = v.junk; I_mem_rlast = v.junk;
      #1;
      chk({tag, "_ar_state"}, state_rr, ST_AR);
      chk({tag, "_arvalid_rr"}, arvalid_rr, 1);
      chk({tag, "_arvalid_fp"}, arvalid_fp, 1);
      chk({tag, "_araddr_rr"}, araddr_rr, a_rr);
      chk({tag, "_araddr_fp"}, araddr_fp, a_fp);
      chk({tag, "_arlen_rr"}, arlen_rr, l_rr);
      chk({tag, "_arlen_fp"}, arlen_fp, l_fp);
      chk({tag, "_arsize"}, arsize_rr, 3'b011);
      chk({tag, "_ar_arready0"}, {ic_arready_rr, dc_arready_rr, ic_arready_fp, dc_arready_fp}, 0);
      chk({tag, "_ar_rvalid0"}, {ic_rvalid_rr, dc_rvalid_rr, ic_rvalid_fp, dc_rvalid_fp}, 0);
    end
    for (int b = 0; b <= int'(l_rr); b++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge I_clk);
        I_mem_arready = 1'b0; I_mem_rvalid = 1'b0; I_mem_rlast = 1'b0;
        #1;
        chk({tag, "_gap_rvalid0"}, {ic_rvalid_rr, dc_rvalid_rr, ic_rvalid_fp, dc_rvalid_fp}, 0);
        chk({tag, "_gap_state"}, state_rr, ST_R);
      end
      @(negedge I_clk);
      I_mem_arready = 1'b0;
      I_mem_rdata = {$urandom, $urandom};
      I_mem_rvalid = 1'b1;
      I_mem_rlast = (b == int'(l_rr));
      exp_q.push_back(I_mem_rdata);
      #1;
      exp_d = exp_q.pop_front();
      chk({tag, "_rdata_rr"}, v.exp_dc_rr ? dc_rdata_rr : ic_rdata_rr, exp_d);
      chk({tag, "_rdata_fp"}, v.exp_dc_fp ? dc_rdata_fp : ic_rdata_fp, exp_d);
      chk({tag, "_rvalid_rr"}, {ic_rvalid_rr, dc_rvalid_rr}, v.exp_dc_rr ? 2'b01 : 2'b10);
      chk({tag, "_rvalid_fp"}, {ic_rvalid_fp, dc_rvalid_fp}, v.exp_dc_fp ? 2'b01 : 2'b10);
      chk({tag, "_rlast_rr"}, {ic_rlast_rr, dc_rlast_rr},
          (b == int'(l_rr)) ? (v.exp_dc_rr ? 2'b01 : 2'b10) : 2'b00);
      chk({tag, "_rlast_fp"}, {ic_rlast_fp, dc_rlast_fp},
          (b == int'(l_fp)) ? (v.exp_dc_fp ? 2'b01 : 2'b10) : 2'b00);
    end
  endtask

  task automatic idle_cycle();
    @(negedge I_clk);
    clear_inputs();
    #1;
    chk("idle_state_rr", state_rr, ST_IDLE);
    chk("idle_state_fp", state_fp, ST_IDLE);
  endtask

  initial begin
    vec_t v;
    I_rst = 1'b1;
    clear_inputs();
    tbl[0] = '{1'b1, 32'h8000_0040, 8'd1, 1'b1, 32'h8000_1000, 8'd3, 0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 32'h8000_0040, 8'd1, 1'b0, 32'h0000_0000, 8'd0, 1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h8000_0000, 8'd3, 1'b0, 32'h0000_0000, 8'd0, 2, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_0100, 8'd0, 1'b1, 32'h0000_0200, 8'd2, 1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0300, 8'd1, 1'b1, 32'h0000_0400, 8'd1, 0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 32'h0000_0500, 8'd0, 2, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 32'h0000_0600, 8'd2, 1'b1, 32'h0000_0700, 8'd2, 1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h0000_0000, 8'd0, 1'b1, 32'h0000_0800, 8'd1, 0, 1'b1, 1'b1, 1'b1};
    repeat (2) @(negedge I_clk);
    do_reset();

    // Table: tie after reset, single requesters, alternating ties, junk in AR.
    for (int i = 0; i < 8; i++) serve(tbl[i], $sformatf("row%0d", i));
    idle_cycle();

    // Continuous requests for four bursts from a fresh reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v = '{1'b1, 32'h9000_0000 + 32'(k * 64), 8'd1, 1'b1, 32'hA000_0000 + 32'(k * 64), 8'd1,
            k % 3, 1'b0, (k % 2 == 0), 1'b1};
      serve(v, $sformatf("cont%0d", k));
    end
    idle_cycle();

    // Reset in the middle of a burst: later beats must be dropped.
    do_reset();
    @(negedge I_clk);
    I_ic_arvalid = 1'b1; I_ic_araddr = 32'h8000_0100; I_ic_arlen = 8'd3;
    #1;
    chk("midrst_accept", ic_arready_rr, 1);
    @(negedge I_clk);
    I_ic_arvalid = 1'b0; I_mem_arready = 1'b1;
    #1;
    chk("midrst_arvalid", arvalid_rr, 1);
    @(negedge I_clk);
    I_mem_arready = 1'b0; I_mem_rvalid = 1'b1; I_mem_rdata = 64'h1111_2222_3333_4444;
    #1;
    chk("midrst_beat1", {ic_rvalid_rr, dc_rvalid_rr}, 2'b10);
    @(negedge I_clk);
    I_rst = 1'b1; I_mem_rdata = 64'h5555_6666_7777_8888;
    #1;
    chk("midrst_beat2_drop", {ic_rvalid_rr, dc_rvalid_rr, ic_rvalid_fp, dc_rvalid_fp}, 0);
    @(negedge I_clk);
    I_rst = 1'b0; I_mem_rdata = 64'h9999_aaaa_bbbb_cccc;
    #1;
    chk("midrst_beat3_drop", {ic_rvalid_rr, dc_rvalid_rr, ic_rlast_rr, dc_rlast_rr}, 0);
    chk("midrst_arvalid0", {arvalid_rr, ic_arready_rr, dc_arready_rr}, 0);
    chk("midrst_state", state_rr, ST_IDLE);
    @(negedge I_clk);
    I_mem_rlast = 1'b1;
    #1;
    chk("midrst_beat4_drop", {ic_rvalid_rr, ic_rlast_rr, ic_rvalid_fp, ic_rlast_fp}, 0);
    serve('{1'b1, 32'h8000_0200, 8'd1, 1'b0, 32'h0, 8'd0, 0, 1'b0, 1'b0, 1'b0}, "after_rst");

    // Stray beats while idle with no request.
    for (int k = 0; k < 2; k++) begin
      @(negedge I_clk);
      clear_inputs();
      I_mem_rvalid = 1'b1; I_mem_rlast = 1'b1;
      #1;
      chk("idle_junk_rvalid", {ic_rvalid_rr, dc_rvalid_rr, ic_rvalid_fp, dc_rvalid_fp}, 0);
      chk("idle_junk_state", state_rr, ST_IDLE);
    end
    serve('{1'b0, 32'h0, 8'd0, 1'b1, 32'h8000_3000, 8'd0, 1, 1'b1, 1'b1, 1'b1}, "junk_ar");
    idle_cycle();

    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_memrd_arbiter.md
YSYX_22040750_MEMRD_ARBITER -- requirements
Module: ysyx_22040750_memrd_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin tie-break and 0 = fixed priority with dcache winning ties.
REQ-002 The block SHALL have port I_clk, input, 1, the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port I_rst, input, 1, the reset: synchronous, active-high.
REQ-004 The block SHALL have port I_ic_araddr, input, 32, icache read burst address.
REQ-005 The block SHALL have port I_ic_arlen, input, 8, icache burst length minus 1.
REQ-006 The block SHALL have port I_ic_arvalid, input, 1, icache read request.
REQ-007 The block SHALL have port O_ic_arready, output, 1, icache request accepted.
REQ-008 The block SHALL have port O_ic_rdata, output, 64, read beat data to icache.
REQ-009 The block SHALL have port O_ic_rvalid, output, 1, beat valid to icache.
REQ-010 The block SHALL have port O_ic_rlast, output, 1, last beat to icache.
REQ-011 The block SHALL have ports I_dc_araddr/I_dc_arlen/I_dc_arvalid/O_dc_arready/O_dc_rdata/O_dc_rvalid/O_dc_rlast, with the same directions, widths and meanings as REQ-004..010, for the dcache.
REQ-012 The block SHALL have port O_mem_araddr, output, 32, AXI AR address.
REQ-013 The block SHALL have port O_mem_arlen, output, 8, AXI AR length.
REQ-014 The block SHALL have port O_mem_arsize, output, 3, constant 3'b011 (8 B).
REQ-015 The block SHALL have port O_mem_arvalid, output, 1, AXI AR valid.
REQ-016 The block SHALL have port I_mem_arready, input, 1, AXI AR ready.
REQ-017 The block SHALL have ports I_mem_rdata, input, 64; I_mem_rvalid, input, 1; I_mem_rlast, input, 1: the AXI R beat.
REQ-018 The block SHALL have port O_mem_rready, output, 1, constant 1.

Function
REQ-019 The FSM SHALL have three states: IDLE, AR and R; at most one burst is outstanding at any time.
REQ-020 IDLE: when any arvalid is high, the block SHALL pick a winner and assert that requester's arready for exactly that cycle, latch its araddr/arlen and the grant ID, and move to AR.
REQ-021 Both arready outputs SHALL be 0 outside IDLE and 0 for the losing requester.
REQ-022 Tie-break with RR_EN=1: the winner SHALL be the requester not granted last; last_grant updates when the burst completes.
REQ-023 Tie-break with RR_EN=0: dcache SHALL always win a tie.
REQ-024 A single requester SHALL be granted regardless of last_grant.
REQ-025 AR: O_mem_arvalid SHALL be 1, with the latched address/length held stable, until the cycle I_mem_arready=1; the FSM then moves to R.
REQ-026 O_mem_arvalid SHALL be 0 in IDLE and R; the first AR is issued 1 cycle after acceptance.
REQ-027 R: I_mem_rdata SHALL go to both rdata outputs, while rvalid/rlast are forwarded combinationally (0-cycle latency) only to the granted requester; the other requester SHALL see rvalid=rlast=0.
REQ-028 R: on the cycle I_mem_rvalid && I_mem_rlast, the FSM SHALL go to IDLE and a new grant SHALL be possible on the next cycle.
REQ-029 I_mem_rvalid seen in IDLE or AR SHALL be dropped and not forwarded.
REQ-030 arlen SHALL be passed through unchanged; beats are counted only through rlast, with no internal beat counter.
REQ-031 With RR_EN=1, a continuously requesting master SHALL wait at most one other burst.

Reset
REQ-032 While I_rst=1 the block SHALL force state IDLE, last_grant=icache (so dcache wins the first tie), latched address/length/grant = 0, and all arready/arvalid/rvalid/rlast outputs = 0; rdata outputs follow I_mem_rdata.
REQ-033 Reset asserted mid-AR or mid-R SHALL abort the burst; beats arriving after reset is released SHALL be dropped per REQ-029.

Verification
REQ-034 icache-only request, araddr 0x8000_0000, arlen 3, mem arready 2 cycles late, 4 beats -> O_ic_arready 1 cycle, AR carries 0x8000_0000/3/3'b011, O_ic_rvalid x4 with rlast on the 4th, O_dc_rvalid stays 0, IDLE next cycle.
REQ-035 After reset, icache 0x8000_0040 and dcache 0x8000_1000 request in the same cycle -> dcache granted first; icache granted in the cycle after dcache's rlast; second AR carries 0x8000_0040.
REQ-036 Both request continuously for 4 bursts: RR_EN=1 -> grants alternate dc,ic,dc,ic; RR_EN=0 -> dc four times and ic never.
REQ-037 I_rst pulsed during the 2nd R beat -> all outputs are 0 the next cycle, the remaining 2 beats are not forwarded, and the next request is served normally.
REQ-038 I_mem_rvalid=1 injected while IDLE with no request, and during AR -> O_ic_rvalid=O_dc_rvalid=0 and the state is unchanged.
